arbitro_4_1: RTL
================

# arbitro_4_1

Round-robin arbiter that shares one 4-input datapath multiplexer between four requesters. Each requester raises a request and keeps ownership until it drops the request. The arbiter registers a one-hot grant and the matching 2-bit select, then drives the shared output through an internal `mux_4_1`. It sits between the requesting units and any downstream consumer of the shared bus.

## Interface
Parameters:
- `ANCHO`, 8: data width of each input and of the output.
- `MAX_CICLOS`, 16: maximum grant duration in cycles. Used only when the timeout feature is compiled in. Legal range is 2..255.

Ports:
- `clk_i`  input  1  single clock; all state updates on the rising edge.
- `rst_n_i`  input  1  reset, asynchronous, active-low.
- `solicitud_i`  input  4  request per requester; held high for as long as ownership is wanted.
- `entrada0_i` .. `entrada3_i`  input  ANCHO each  requester data.
- `concesion_o`  output  4  registered one-hot grant; all zeros when idle.
- `seleccion_o`  output  2  registered index of the owner; drives the mux select.
- `valido_o`  output  1  registered; high while a grant is active.
- `datos_o`  output  ANCHO  selected data when `valido_o`=1, otherwise 0. Combinational from registered select.
- `timeout_o`  output  1  one-cycle pulse when a grant is revoked by timeout. Tied to 0 when the feature is off.

## Operation
- The FSM has two states, LIBRE and CONCEDIDO.
- The arbiter keeps an internal 2-bit pointer `puntero`, the first index searched. It resets to 0.
- Search rule: among eligible request bits, pick the first set bit starting at `puntero` and wrapping 3→0.
- **LIBRE**, any eligible request: grant the search winner and go to CONCEDIDO.
- **LIBRE**, no request: stay in LIBRE, with `concesion_o`=0, `valido_o`=0 and `seleccion_o` unchanged.
- **CONCEDIDO**, owner request still high: hold the grant. New requests from others are ignored.
- **CONCEDIDO**, owner request low: set `puntero` to owner+1 (mod 4) and search in the same edge.
  - If a winner exists, hand the grant to it directly, with no idle cycle.
  - If no winner exists, go to LIBRE.
- The owner can never win its own re-arbitration at a release edge.
- Grant output values:
  - `concesion_o` equals 1 shifted left by `seleccion_o` whenever `valido_o`=1.
  - `concesion_o` has at most one bit set at any time.
- Reset: asynchronous clear of the FSM (to LIBRE), `puntero`, the timeout counter and the mask. While `rst_n_i`=0, every registered output is 0. Requests are ignored during reset.

## Timing
- Request-to-grant latency is 1 edge. A request sampled high at edge n gives `concesion_o` high after edge n.
- Release-to-handoff latency is 1 edge. The owner drops its request before edge n, and the new owner is visible after edge n.
- `datos_o` follows `seleccion_o` combinationally in the same cycle.
- Reset may be asserted mid-grant. The outputs drop immediately, without waiting for a clock edge.
- After `rst_n_i` deasserts, the first grant occurs at the first edge with a request present.

## Configuration
- The macro is `ARBITRO_TIMEOUT_EN`.
- **Defined:**
  - A counter of width `$clog2(MAX_CICLOS+1)` counts grant cycles and restarts at every new grant, including direct handoffs.
  - On the edge that ends the `MAX_CICLOS`-th cycle of a grant, that grant is revoked. The revocation uses the same search as a release, from owner+1.
  - `timeout_o` pulses for 1 cycle on revocation.
  - The revoked requester is set in a 4-bit mask and is ineligible until it drops its request for at least one sampled edge.
- **Undefined:**
  - There is no counter and no mask.
  - `timeout_o` is 0.
  - A grant lasts indefinitely.

## Structure
- Package `arbitro_pkg` holds:
  - `N_SOLICITANTES` = 4;
  - `typedef logic [1:0] indice_t`;
  - `typedef enum logic {LIBRE, CONCEDIDO} estado_t`;
  - a function `buscar_rr(solicitudes, puntero)` returning the winning index and a found flag.
- The sub-module is `mux_4_1` (parameter `ANCHO`). Its select is driven by `seleccion_o` and its output is gated by `valido_o` to form `datos_o`.

## Test plan
- **Reset:** hold `rst_n_i`=0 with `solicitud_i`=4'b1111 → `concesion_o`=0, `valido_o`=0, `seleccion_o`=0, `datos_o`=0, `timeout_o`=0.
- **Single request:** after reset, `solicitud_i`=4'b0010 and `entrada1_i`=8'hA5 → after 1 edge, `concesion_o`=4'b0010, `seleccion_o`=1, `datos_o`=8'hA5.
- **Rotation:** `solicitud_i`=4'b1111 from reset → grant to 0. Drop each owner's bit for 1 cycle in turn → grants go 0→1→2→3→0 with no idle cycle between them.
- **Hold:** requester 2 owns the grant while 0, 1 and 3 request for 20 cycles → the grant stays 4'b0100 throughout. Release → grant 3.
- **Timeout** (macro defined, `MAX_CICLOS`=4): requester 0 holds with requester 1 pending → after the 4th grant cycle, grant 1 and a 1-cycle `timeout_o` pulse. Requester 0 stays ineligible until it drops its request.
- **Mid-grant reset:** pull `rst_n_i` low between edges while `valido_o`=1 → outputs go to 0 immediately. On release of reset, `puntero`=0, so requests 4'b1010 → grant 1.

Source files
------------

// File: rtl/arbitro_pkg.sv
// Shared types and the round-robin search used by the 4-input arbiter.
// Pure declarations: no state, no latency, no flow control.
package arbitro_pkg;

  localparam int N_SOLICITANTES = 4;

  typedef logic [1:0] indice_t;

  typedef enum logic {LIBRE, CONCEDIDO} estado_t;

  typedef struct packed {
    logic    encontrado;
    indice_t indice;
  } busqueda_t;

  // Walks from the highest offset down so the offset closest to puntero is written last and wins.
  function automatic busqueda_t buscar_rr(input logic [N_SOLICITANTES-1:0] solicitudes,
                                          input indice_t puntero);
    busqueda_t res;
    indice_t   idx;
    res = '0;
    for (int i = N_SOLICITANTES - 1; i >= 0; i--) begin
      idx = puntero + indice_t'(i);
      if (solicitudes[idx]) begin
        res.encontrado = 1'b1;
        res.indice     = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_4_1.sv
// Four-way datapath multiplexer for the shared bus.
// Combinational, zero latency; no flow control.
module mux_4_1 #(
  parameter int ANCHO = 8
) (
  input  logic [1:0]       sel,
  input  logic [ANCHO-1:0] in0,
  input  logic [ANCHO-1:0] in1,
  input  logic [ANCHO-1:0] in2,
  input  logic [ANCHO-1:0] in3,
  output logic [ANCHO-1:0] out
);

  always_comb begin
    out = in0;
    unique case (sel)
      2'd0: out = in0;
      2'd1: out = in1;
      2'd2: out = in2;
      2'd3: out = in3;
    endcase
  end

endmodule

// File: rtl/arbitro_4_1.sv
// Round-robin 4:1 bus arbiter with hold-until-release ownership; ARBITRO_TIMEOUT_EN adds grant revocation.
// Grant 1 edge after request, handoff 1 edge after release; requesters wait while another owns the bus.
module arbitro_4_1
  import arbitro_pkg::*;
#(
  parameter int ANCHO      = 8,
  parameter int MAX_CICLOS = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [N_SOLICITANTES-1:0] solicitud_i,
  input  logic [ANCHO-1:0]          entrada0_i,
  input  logic [ANCHO-1:0]          entrada1_i,
  input  logic [ANCHO-1:0]          entrada2_i,
  input  logic [ANCHO-1:0]          entrada3_i,
  output logic [N_SOLICITANTES-1:0] concesion_o,
  output indice_t                   seleccion_o,
  output logic                      valido_o,
  output logic [ANCHO-1:0]          datos_o,
  output logic                      timeout_o
);

  localparam logic [N_SOLICITANTES-1:0] UNO = 4'b0001;

  if (MAX_CICLOS < 2 || MAX_CICLOS > 255) begin : g_rango
    $error("arbitro_4_1: MAX_CICLOS must lie in 2..255");
  end

  estado_t                   estado;
  indice_t                   puntero;
  indice_t                   siguiente;
  logic                      pide_dueno;
  logic                      revocar;
  logic                      liberar;
  logic [N_SOLICITANTES-1:0] elegibles;
  logic [N_SOLICITANTES-1:0] candidatos;
  busqueda_t                 gana_libre;
  busqueda_t                 gana_relevo;
  logic [ANCHO-1:0]          dato_mux;

`ifdef ARBITRO_TIMEOUT_EN
  localparam int CW = $clog2(MAX_CICLOS + 1);

  logic [CW-1:0]             contador;
  logic [N_SOLICITANTES-1:0] mascara;
  logic                      timeout_q;

  assign elegibles = solicitud_i & ~mascara;
  assign revocar   = (estado == CONCEDIDO) && pide_dueno && (contador == CW'(MAX_CICLOS));
  assign timeout_o = timeout_q;
`else
  assign elegibles = solicitud_i;
  assign revocar   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign pide_dueno = solicitud_i[seleccion_o];
  assign siguiente  = seleccion_o + 2'd1;
  assign liberar    = !pide_dueno || revocar;
  // The outgoing owner is excluded so it cannot win its own re-arbitration.
  assign candidatos  = elegibles & ~(UNO << seleccion_o);
  assign gana_libre  = buscar_rr(elegibles, puntero);
  assign gana_relevo = buscar_rr(candidatos, siguiente);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      estado      <= LIBRE;
      puntero     <= '0;
      seleccion_o <= '0;
      concesion_o <= '0;
      valido_o    <= 1'b0;
`ifdef ARBITRO_TIMEOUT_EN
      contador    <= '0;
      mascara     <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef ARBITRO_TIMEOUT_EN
      timeout_q <= revocar;
      // A masked requester becomes eligible again once it has been seen low.
      mascara   <= (mascara & solicitud_i) | (revocar ? (UNO << seleccion_o) : '0);
`endif
      unique case (estado)
        LIBRE: begin
          if (gana_libre.encontrado) begin
            estado      <= CONCEDIDO;
            seleccion_o <= gana_libre.indice;
            concesion_o <= UNO << gana_libre.indice;
            valido_o    <= 1'b1;
`ifdef ARBITRO_TIMEOUT_EN
            contador    <= CW'(1);
`endif
          end else begin
            concesion_o <= '0;
            valido_o    <= 1'b0;
          end
        end
        CONCEDIDO: begin
          if (liberar) begin
            puntero <= siguiente;
            if (gana_relevo.encontrado) begin
              seleccion_o <= gana_relevo.indice;
              concesion_o <= UNO << gana_relevo.indice;
              valido_o    <= 1'b1;
`ifdef ARBITRO_TIMEOUT_EN
              contador    <= CW'(1);
`endif
            end else begin
              estado      <= LIBRE;
              concesion_o <= '0;
              valido_o    <= 1'b0;
            end
          end else begin
`ifdef ARBITRO_TIMEOUT_EN
            contador <= contador + CW'(1);
`endif
          end
        end
      endcase
    end
  end

  mux_4_1 #(.ANCHO(ANCHO)) u_mux (
    .sel (seleccion_o),
    .in0 (entrada0_i),
    .in1 (entrada1_i),
    .in2 (entrada2_i),
    .in3 (entrada3_i),
    .out (dato_mux)
  );

  assign datos_o = valido_o ? dato_mux : '0;

endmodule
